// File: rtl/soc_noc_loopback_pkg.sv
// Shared definitions for the NoC loopback endpoint: header field layout,
// ingress state encoding and the return-path header rewrite.
package soc_noc_loopback_pkg;

   localparam int DEST_W    = 5;
   localparam int CLASS_W   = 3;
   localparam int SRC_W     = 5;
   localparam int HDR_W     = DEST_W + CLASS_W + SRC_W;

   // Positions are relative to the HDR_W-bit slice at the top of a flit
   localparam int DEST_MSB  = HDR_W - 1;
   localparam int CLASS_MSB = DEST_MSB - DEST_W;
   localparam int SRC_MSB   = CLASS_MSB - CLASS_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      DROP = 2'd2
   } ingress_state_e;

   function automatic logic [HDR_W-1:0] swap_header(input logic [HDR_W-1:0] hdr,
                                                     input logic [SRC_W-1:0] id);
      logic [HDR_W-1:0] res;
      res                     = hdr;
      res[DEST_MSB -: DEST_W] = hdr[SRC_MSB -: SRC_W];
      res[SRC_MSB -: SRC_W]   = id;
      return res;
   endfunction

endpackage

// File: rtl/soc_noc_flit_fifo.sv
// Synchronous {last, flit} FIFO with a combinational head and
// full/empty/count status; storage itself is not reset.
module soc_noc_flit_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0) && (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointers wrap modulo DEPTH, so their top bit stays clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= {1'b0, AW'(wr_ptr[AW-1:0] + 1'b1)};
         end
         if (do_pop) begin
            rd_ptr <= {1'b0, AW'(rd_ptr[AW-1:0] + 1'b1)};
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (!do_push && do_pop) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/soc_noc_loopback_endpoint.sv
// Store-and-forward NoC loopback: returns every packet to its sender with
// DEST/SRC rewritten. Define SOC_NOC_LOOPBACK_STATS_EN for return counters.
module soc_noc_loopback_endpoint
   import soc_noc_loopback_pkg::*;
#(
   parameter int FLIT_WIDTH  = 32,
   parameter int ENDPOINT_ID = 1,
   parameter int MAX_PKT_LEN = 8,
   parameter int DEPTH       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] noc_in_flit,
   input  logic                  noc_in_last,
   input  logic                  noc_in_valid,
   output logic                  noc_in_ready,
   output logic [FLIT_WIDTH-1:0] noc_out_flit,
   output logic                  noc_out_last,
   output logic                  noc_out_valid,
   input  logic                  noc_out_ready
`ifdef SOC_NOC_LOOPBACK_STATS_EN
   ,
   output logic [31:0]           stat_pkts_returned,
   output logic [31:0]           stat_flits_returned,
   output logic [31:0]           stat_pkts_truncated
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int LW = $clog2(MAX_PKT_LEN + 1);
   localparam logic [SRC_W-1:0] ID_FIELD = SRC_W'(ENDPOINT_ID);

   ingress_state_e          state_q;
   ingress_state_e          state_d;
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           len_d;
   logic [CW-1:0]           pkt_cnt_q;
   logic                    out_first_q;

   logic                    in_fire;
   logic                    wr_en;
   logic                    wr_last;
   logic                    trunc;
   logic                    pop;
   logic                    pkt_inc;
   logic                    pkt_dec;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW-1:0]           fifo_count_unused;
   logic [FLIT_WIDTH:0]     head_data;
   logic [FLIT_WIDTH-1:0]   head_flit;
   logic                    head_last;

   assign {head_last, head_flit} = head_data;

   soc_noc_flit_fifo #(
      .WIDTH (FLIT_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data ({wr_last, noc_in_flit}),
      .pop       (pop),
      .pop_data  (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

   // ---- Ingress: header/body tracking, truncation and drop ----
   assign noc_in_ready = !rst && ((state_q == DROP) || !fifo_full);
   assign in_fire      = noc_in_valid && noc_in_ready;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wr_en   = 1'b0;
      wr_last = noc_in_last;
      trunc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               wr_en = 1'b1;
               len_d = LW'(1);
               if (!noc_in_last) begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            if (in_fire) begin
               wr_en = 1'b1;
               len_d = len_q + LW'(1);
               if (noc_in_last) begin
                  state_d = IDLE;
               end else if (len_q + LW'(1) == LW'(MAX_PKT_LEN)) begin
                  // Close the stored packet here; the rest is swallowed
                  wr_last = 1'b1;
                  trunc   = 1'b1;
                  state_d = DROP;
               end
            end
         end
         DROP: begin
            if (in_fire && noc_in_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- Egress: only whole packets are visible to the tile ----
   assign noc_out_valid = (pkt_cnt_q != '0) && !fifo_empty;
   assign pop           = noc_out_valid && noc_out_ready;
   assign pkt_inc       = wr_en && wr_last;
   assign pkt_dec       = pop && head_last;

   always_comb begin
      noc_out_flit = '0;
      noc_out_last = 1'b0;
      if (noc_out_valid) begin
         noc_out_flit = head_flit;
         noc_out_last = head_last;
         if (out_first_q) begin
            noc_out_flit[FLIT_WIDTH-1 -: HDR_W] =
               swap_header(head_flit[FLIT_WIDTH-1 -: HDR_W], ID_FIELD);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         pkt_cnt_q   <= '0;
         out_first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         if (pkt_inc && !pkt_dec) begin
            pkt_cnt_q <= pkt_cnt_q + CW'(1);
         end else if (!pkt_inc && pkt_dec) begin
            pkt_cnt_q <= pkt_cnt_q - CW'(1);
         end
         if (pop) begin
            out_first_q <= head_last;
         end
      end
   end

`ifdef SOC_NOC_LOOPBACK_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_pkts_returned  <= '0;
         stat_flits_returned <= '0;
         stat_pkts_truncated <= '0;
      end else begin
         if (pkt_dec) begin
            stat_pkts_returned <= sat_inc(stat_pkts_returned);
         end
         if (pop) begin
            stat_flits_returned <= sat_inc(stat_flits_returned);
         end
         if (trunc) begin
            stat_pkts_truncated <= sat_inc(stat_pkts_truncated);
         end
      end
   end
`endif

endmodule

// File: tb/tb_soc_noc_loopback_endpoint.sv
// Bench for soc_noc_loopback_endpoint: table of packets with hand-derived
// return headers, a scoreboard queue, and hand sequences for corner cases.
module tb_soc_noc_loopback_endpoint;

   localparam int W  = 32;
   localparam int NV = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  noc_in_flit = '0;
   logic          noc_in_last = 1'b0;
   logic          noc_in_valid = 1'b0;
   logic          noc_in_ready;
   logic [W-1:0]  noc_out_flit;
   logic          noc_out_last;
   logic          noc_out_valid;
   logic          noc_out_ready = 1'b0;
`ifdef SOC_NOC_LOOPBACK_STATS_EN
   logic [31:0]   stat_pkts_returned;
   logic [31:0]   stat_flits_returned;
   logic [31:0]   stat_pkts_truncated;
`endif

   soc_noc_loopback_endpoint #(
      .FLIT_WIDTH  (W),
      .ENDPOINT_ID (1),
      .MAX_PKT_LEN (8),
      .DEPTH       (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .noc_in_flit   (noc_in_flit),
      .noc_in_last   (noc_in_last),
      .noc_in_valid  (noc_in_valid),
      .noc_in_ready  (noc_in_ready),
      .noc_out_flit  (noc_out_flit),
      .noc_out_last  (noc_out_last),
      .noc_out_valid (noc_out_valid),
      .noc_out_ready (noc_out_ready)
`ifdef SOC_NOC_LOOPBACK_STATS_EN
      ,
      .stat_pkts_returned  (stat_pkts_returned),
      .stat_flits_returned (stat_flits_returned),
      .stat_pkts_truncated (stat_pkts_truncated)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] flit;
      logic         last;
   } exp_t;

   typedef struct {
      logic [W-1:0] hdr;
      int           len;
      logic [W-1:0] pay [11];
      logic [W-1:0] exp_hdr;
      int           exp_len;
   } vec_t;

   exp_t sb [$];
   vec_t vecs [NV];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_flit(input logic [W-1:0] f, input logic l);
      exp_t e;
      e.flit = f;
      e.last = l;
      sb.push_back(e);
   endtask

   // Output monitor: a transfer happens at the next rising edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst && noc_out_valid && noc_out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%08h with nothing expected", noc_out_flit);
         end else begin
            e = sb.pop_front();
            check("out_flit", noc_out_flit, e.flit);
            check("out_last", noc_out_last, e.last);
         end
      end
   end

   task automatic drive_flit(input logic [W-1:0] f, input logic l, output int stalls);
      stalls       = 0;
      noc_in_flit  = f;
      noc_in_last  = l;
      noc_in_valid = 1'b1;
      @(negedge clk);
      while (!noc_in_ready && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (!noc_in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_timeout: noc_in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
      noc_in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((sb.size() != 0 || noc_out_valid) && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain_left", sb.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int st;
      int st_sum;
      exp_t e;
      logic [W-1:0] h;

      // Table of packets; return headers worked out by hand from the field layout
      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < 11; k++) vecs[i].pay[k] = 32'hC000_0000 + (i << 8) + k;
      end
      vecs[0].hdr = 32'h1000_0000; vecs[0].len = 1;  vecs[0].exp_hdr = 32'h0008_0000; vecs[0].exp_len = 1;
      vecs[1].hdr = 32'h0010_0000; vecs[1].len = 1;  vecs[1].exp_hdr = 32'h1008_0000; vecs[1].exp_len = 1;
      vecs[2].hdr = 32'h5A3C_1234; vecs[2].len = 3;  vecs[2].exp_hdr = 32'h3A0C_1234; vecs[2].exp_len = 3;
      vecs[2].pay[0] = 32'hA5A5_A5A5;
      vecs[2].pay[1] = 32'h5A5A_5A5A;
      vecs[3].hdr = 32'h0010_0000; vecs[3].len = 12; vecs[3].exp_hdr = 32'h1008_0000; vecs[3].exp_len = 8;
      vecs[4].hdr = 32'hFFFF_FFFF; vecs[4].len = 8;  vecs[4].exp_hdr = 32'hFF0F_FFFF; vecs[4].exp_len = 8;
      vecs[5].hdr = 32'h0800_0000; vecs[5].len = 9;  vecs[5].exp_hdr = 32'h0008_0000; vecs[5].exp_len = 8;
      vecs[6].hdr = 32'h0018_0000; vecs[6].len = 2;  vecs[6].exp_hdr = 32'h1808_0000; vecs[6].exp_len = 2;

      // Reset state
      #12;
      check("rst_out_valid", noc_out_valid, 1'b0);
      check("rst_out_last", noc_out_last, 1'b0);
      check("rst_out_flit", noc_out_flit, 32'h0);
      check("rst_in_ready", noc_in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", noc_in_ready, 1'b1);

      // Single-flit latency: visible right after the accepting edge
      noc_out_ready = 1'b1;
      expect_flit(32'h1008_0000, 1'b1);
      drive_flit(32'h0010_0000, 1'b1, st);
      check("lat1_valid", noc_out_valid, 1'b1);
      check("lat1_flit", noc_out_flit, 32'h1008_0000);
      wait_drain();

      // Table-driven packets
      for (int i = 0; i < NV; i++) begin
         st_sum = 0;
         expect_flit(vecs[i].exp_hdr, vecs[i].exp_len == 1);
         for (int k = 1; k < vecs[i].exp_len; k++) expect_flit(vecs[i].pay[k-1], k == vecs[i].exp_len - 1);
         for (int k = 0; k < vecs[i].len; k++) begin
            if (k == 0) drive_flit(vecs[i].hdr, vecs[i].len == 1, st);
            else        drive_flit(vecs[i].pay[k-1], k == vecs[i].len - 1, st);
            st_sum += st;
         end
         check("vec_in_stalls", st_sum, 0);
         wait_drain();
      end
`ifdef SOC_NOC_LOOPBACK_STATS_EN
      check("stat_truncated", stat_pkts_truncated, 32'd2);
`endif

      // 3-flit packet stays invisible until fully stored
      expect_flit(32'h3A0C_1234, 1'b0);
      expect_flit(32'hA5A5_A5A5, 1'b0);
      expect_flit(32'h5A5A_5A5A, 1'b1);
      drive_flit(32'h5A3C_1234, 1'b0, st);
      check("sf_valid_f1", noc_out_valid, 1'b0);
      drive_flit(32'hA5A5_A5A5, 1'b0, st);
      check("sf_valid_f2", noc_out_valid, 1'b0);
      drive_flit(32'h5A5A_5A5A, 1'b1, st);
      check("sf_valid_f3", noc_out_valid, 1'b1);
      wait_drain();

      // Fill with 2-flit packets under back-pressure
      noc_out_ready = 1'b0;
      for (int p = 0; p < 8; p++) begin
         h = W'(p) << 19;
         expect_flit((W'(p) << 27) | (W'(1) << 19), 1'b0);
         expect_flit(32'hD000_0000 + p, 1'b1);
         drive_flit(h, 1'b0, st);
         drive_flit(32'hD000_0000 + p, 1'b1, st);
      end
      check("full_in_ready", noc_in_ready, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_valid", noc_out_valid, 1'b1);
      check("hold_flit", noc_out_flit, sb[0].flit);
      noc_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("pop_frees_slot", noc_in_ready, 1'b1);
      wait_drain();

      // Back-to-back 1-flit packets: no stalls, pkt_cnt never accumulates
      st_sum = 0;
      for (int p = 0; p < 8; p++) begin
         expect_flit((W'(p + 3) << 27) | (W'(1) << 19) | W'(p), 1'b1);
         drive_flit((W'(p + 3) << 19) | W'(p), 1'b1, st);
         st_sum += st;
      end
      check("b2b_stalls", st_sum, 0);
      check("b2b_valid_last", noc_out_valid, 1'b1);
      @(posedge clk);
      #1;
      check("b2b_drained", noc_out_valid, 1'b0);
      wait_drain();

      // Reset mid-packet discards complete and partial packets
      noc_out_ready = 1'b0;
      expect_flit(32'h1008_0000, 1'b1);
      drive_flit(32'h0010_0000, 1'b1, st);
      drive_flit(32'h5A3C_1234, 1'b0, st);
      drive_flit(32'h1111_1111, 1'b0, st);
      check("prerst_valid", noc_out_valid, 1'b1);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("midrst_valid", noc_out_valid, 1'b0);
      check("midrst_flit", noc_out_flit, 32'h0);
      check("midrst_in_ready", noc_in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("postrst_valid", noc_out_valid, 1'b0);
`ifdef SOC_NOC_LOOPBACK_STATS_EN
      check("postrst_stat_trunc", stat_pkts_truncated, 32'd0);
`endif
      noc_out_ready = 1'b1;
      expect_flit(32'h3A0C_1234, 1'b0);
      expect_flit(32'h1234_5678, 1'b1);
      drive_flit(32'h5A3C_1234, 1'b0, st);
      drive_flit(32'h1234_5678, 1'b1, st);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
